// File: rtl/xfer_responder.sv
// xfer_responder: responder side of the REQ/START/RDY/ENDD/ER/RT/STOP transfer protocol.
// Optional watchdog enabled by defining XFER_RESPONDER_TIMEOUT_EN.
module xfer_responder #(
    parameter int BEAT_W    = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_start,
    input  logic              i_rdy,
    input  logic              i_endd,
    input  logic              i_er,
    input  logic              i_stop,
    input  logic              i_rt,
    output logic              o_ack,
    output logic              o_enable,
    output logic              o_status_valid,
    output logic              o_status_err,
    output logic [BEAT_W-1:0] o_status_beats,
    output logic              o_interrupt,
    output logic              o_busy
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int WW = $clog2(TIMEOUT + 2);
`ifdef XFER_RESPONDER_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACKW, ARMED, XFER, DONE, ERR} state_t;

    state_t            r_state, w_next;
    logic [BEAT_W-1:0] r_beat, w_beat, w_beat_inc;
    logic [RW-1:0]     r_retry, w_retry;
    logic [WW-1:0]     r_wd, w_wd_inc;
    logic              w_wd_hit, w_fin;

    assign w_beat_inc = &r_beat ? r_beat : r_beat + 1'b1;
    assign w_wd_inc   = r_wd + 1'b1;
    assign w_wd_hit   = WD_EN && (w_wd_inc == WW'(TIMEOUT));
    assign w_fin      = (w_next == DONE) || (w_next == ERR);

    always_comb begin
        w_next  = r_state;
        w_beat  = r_beat;
        w_retry = r_retry;
        case (r_state)
            IDLE:  w_next = i_req ? ACKW : IDLE;
            ACKW:  w_next = i_req ? ACKW : ARMED;
            ARMED: if (i_start) begin
                w_next  = XFER;
                w_beat  = '0;
                w_retry = '0;
            end
            XFER: if (i_stop) w_next = IDLE;
            else if (i_er) w_next = ERR;
            else if (i_rt) begin
                if (r_retry == RW'(MAX_RETRY)) w_next = ERR;
                else begin
                    w_retry = r_retry + 1'b1;
                    w_beat  = '0;
                end
            end
            else if (i_endd) begin
                w_next = DONE;
                w_beat = i_rdy ? w_beat_inc : r_beat;
            end
            else if (i_rdy) w_beat = w_beat_inc;
            else if (w_wd_hit) w_next = ERR;
            default: w_next = IDLE;
        endcase
    end

    // Watchdog idles at zero outside XFER, so entering XFER always starts from a clean count.
    always_ff @(posedge clk) begin
        if (!rst || !WD_EN || r_state != XFER || i_rdy || i_rt || i_endd) r_wd <= '0;
        else r_wd <= w_wd_inc;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_beat         <= '0;
            r_retry        <= '0;
            o_ack          <= 1'b0;
            o_enable       <= 1'b0;
            o_busy         <= 1'b0;
            o_status_valid <= 1'b0;
            o_status_err   <= 1'b0;
            o_status_beats <= '0;
            o_interrupt    <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_beat         <= w_beat;
            r_retry        <= w_retry;
            o_ack          <= w_next == ACKW;
            o_enable       <= w_next == XFER;
            o_busy         <= w_next != IDLE;
            o_status_valid <= w_fin;
            o_status_err   <= w_next == ERR;
            o_interrupt    <= w_fin;
            if (w_fin) o_status_beats <= w_beat;
        end
    end
endmodule

// File: tb/tb_xfer_responder.sv
// tb_xfer_responder: scoreboard bench; expected status records are queued as strobes are driven.
module tb_xfer_responder;
    logic       clk = 1'b0, rst = 1'b0;
    logic       req = 1'b0, start = 1'b0, rdy = 1'b0, endd = 1'b0, er = 1'b0, stop = 1'b0, rt = 1'b0;
    logic       ack, enable, status_valid, status_err, interrupt, busy;
    logic [7:0] status_beats;

    typedef struct packed {
        logic       err;
        logic [7:0] beats;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0, n_fail = 0, n_pulse = 0, n_exp = 0;

    xfer_responder #(.BEAT_W(8), .MAX_RETRY(3), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_start(start), .i_rdy(rdy), .i_endd(endd),
        .i_er(er), .i_stop(stop), .i_rt(rt), .o_ack(ack), .o_enable(enable),
        .o_status_valid(status_valid), .o_status_err(status_err), .o_status_beats(status_beats),
        .o_interrupt(interrupt), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic err, input logic [7:0] beats);
        sb.push_back('{err: err, beats: beats});
        n_exp++;
    endtask

    always @(negedge clk) begin
        if (status_valid) begin
            n_pulse++;
            chk("irq", interrupt, 1);
            if (sb.size() == 0) chk("unexpected_status", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("status_err", status_err, e.err);
                chk("status_beats", status_beats, e.beats);
            end
        end else if (status_err || interrupt) chk("err_irq_idle", {status_err, interrupt}, 0);
    end

    task automatic open_xfer();
        req = 1'b1;
        cyc(1);
        chk("ack_rise", ack, 1);
        cyc(2);
        chk("ack_hold", ack, 1);
        req = 1'b0;
        cyc(1);
        chk("ack_fall", ack, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("enable_on", enable, 1);
    endtask

    task automatic beats(input int n);
        rdy = 1'b1;
        cyc(n);
        rdy = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_outs", {ack, enable, status_valid, status_err, interrupt, busy}, 0);
        chk("rst_beats", status_beats, 0);
        rst = 1'b1;
        cyc(1);

        // reset mid-transfer
        open_xfer();
        beats(2);
        rst = 1'b0;
        cyc(1);
        chk("midrst_outs", {ack, enable, busy, status_valid, interrupt}, 0);
        rst = 1'b1;
        cyc(1);

        // basic transfer with 5 beats
        open_xfer();
        beats(5);
        endd = 1'b1;
        push(1'b0, 8'd5);
        cyc(1);
        endd = 1'b0;
        chk("done_lat", status_valid, 1);
        chk("done_enable", enable, 0);
        cyc(1);
        chk("pulse_len", status_valid, 0);
        chk("idle_busy", busy, 0);
        chk("beats_hold", status_beats, 5);

        // retry clears beat count
        open_xfer();
        beats(2);
        rt = 1'b1;
        cyc(1);
        rt = 1'b0;
        beats(3);
        endd = 1'b1;
        push(1'b0, 8'd3);
        cyc(1);
        endd = 1'b0;
        cyc(1);

        // rdy discarded with rt, counted with endd
        open_xfer();
        beats(3);
        rt = 1'b1;
        rdy = 1'b1;
        cyc(1);
        rt = 1'b0;
        cyc(1);
        endd = 1'b1;
        push(1'b0, 8'd2);
        cyc(1);
        endd = 1'b0;
        rdy = 1'b0;
        cyc(1);

        // fourth retry is fatal
        open_xfer();
        beats(1);
        rt = 1'b1;
        cyc(3);
        chk("rt3_alive", {status_valid, enable}, 2'b01);
        push(1'b1, 8'd0);
        cyc(1);
        rt = 1'b0;
        chk("rt4_fatal", {status_valid, status_err}, 2'b11);
        cyc(1);

        // stop beats er: no status
        open_xfer();
        beats(2);
        stop = 1'b1;
        er = 1'b1;
        cyc(1);
        stop = 1'b0;
        er = 1'b0;
        chk("stop_outs", {enable, busy, status_valid}, 0);
        cyc(2);

        // er beats endd
        open_xfer();
        beats(2);
        er = 1'b1;
        endd = 1'b1;
        push(1'b1, 8'd2);
        cyc(1);
        er = 1'b0;
        endd = 1'b0;
        chk("er_endd", status_err, 1);
        cyc(1);

        // strobes outside XFER ignored, then saturation
        endd = 1'b1;
        er = 1'b1;
        rt = 1'b1;
        cyc(2);
        chk("idle_ignore", busy, 0);
        endd = 1'b0;
        er = 1'b0;
        rt = 1'b0;
        open_xfer();
        beats(260);
        endd = 1'b1;
        push(1'b0, 8'd255);
        cyc(1);
        endd = 1'b0;
        chk("sat_beats", status_beats, 255);
        cyc(1);

        // req held through completion restarts handshake from IDLE
        open_xfer();
        req = 1'b1;
        endd = 1'b1;
        push(1'b0, 8'd0);
        cyc(1);
        endd = 1'b0;
        chk("req_done_ack", ack, 0);
        cyc(1);
        chk("req_idle_ack", ack, 0);
        cyc(1);
        chk("req_rehandshake", ack, 1);
        req = 1'b0;
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("armed_stop_ignored", busy, 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;

        // idle XFER: watchdog or indefinite wait
        open_xfer();
`ifdef XFER_RESPONDER_TIMEOUT_EN
        push(1'b1, 8'd0);
        cyc(15);
        chk("wd_early", status_valid, 0);
        cyc(1);
        chk("wd_fire", {status_valid, status_err}, 2'b11);
        cyc(1);
`else
        cyc(20);
        chk("no_wd_enable", enable, 1);
        chk("no_wd_valid", status_valid, 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
`endif
        cyc(3);
        chk("sb_empty", sb.size(), 0);
        chk("pulse_cnt", n_pulse, n_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xfer_responder.md
Name: xfer_responder

Overview:
- Responder end of the RT/RDY/START/ENDD/ER/STOP/REQ control protocol. The initiator drives these strobes; this block answers them.
- Handshakes REQ/ACK and tracks one transfer from START to ENDD.
- Counts RDY beats and handles retry (RT), error (ER) and abort (STOP).
- Reports completion with a one-cycle STATUS_VALID/INTERRUPT pulse. It sits directly opposite the initiator in the control path.

Parameters:
- BEAT_W, 8, width of the beat counter and of status_beats.
- MAX_RETRY, 3, number of RT strobes tolerated in one transfer; the next RT is fatal.
- TIMEOUT, 16, idle-cycle limit for the watchdog (used only with the optional feature).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- req  input  1  initiator request (level)
- start  input  1  transfer start strobe
- rdy  input  1  data-beat strobe
- endd  input  1  transfer end strobe
- er  input  1  initiator error strobe
- stop  input  1  abort strobe
- rt  input  1  retry strobe
- ack  output  1  request acknowledge
- enable  output  1  high while a transfer is active
- status_valid  output  1  one-cycle completion pulse
- status_err  output  1  qualifies status_valid: 1 = failed
- status_beats  output  BEAT_W  beats counted; valid with status_valid
- interrupt  output  1  one-cycle pulse coincident with status_valid
- busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. rst=0 at a clock edge forces the following, regardless of state, including mid-transfer:
  - state IDLE
  - all outputs 0
  - beat_cnt and retry_cnt cleared
- FSM states: IDLE, ACKW, ARMED, XFER, DONE, ERR.
- IDLE:
  - req=1 -> ACKW; ack=1 from the next cycle.
  - All other inputs are ignored.
- ACKW (4-phase handshake):
  - ack stays 1 while req=1.
  - req=0 -> ARMED; ack=0 on the next cycle.
- ARMED:
  - start=1 -> XFER; enable=1 on the next cycle; beat_cnt=0; retry_cnt=0.
  - Other strobes are ignored.
- XFER, per-cycle priority stop > er > rt > endd > rdy:
  - stop: -> IDLE; enable=0; no status pulse.
  - er: -> ERR.
  - rt:
    - If retry_cnt==MAX_RETRY -> ERR.
    - Otherwise retry_cnt+1, beat_cnt=0, stay in XFER.
    - A rdy in the same cycle is discarded.
  - endd: -> DONE. A rdy in the same cycle is counted.
  - rdy alone: beat_cnt+1. It saturates at 2^BEAT_W-1 and does not wrap.
- DONE, one cycle:
  - status_valid=1, status_err=0, status_beats=beat_cnt, interrupt=1, enable=0.
  - -> IDLE.
- ERR, one cycle:
  - status_valid=1, status_err=1, status_beats=beat_cnt, interrupt=1, enable=0.
  - -> IDLE.
- Latency: status_valid is high exactly 1 cycle after endd (or the fatal er/rt) is sampled.
- status_beats holds its value until the next status_valid; status_err is 0 whenever status_valid=0.
- req asserted outside IDLE is ignored until the FSM returns to IDLE. If req is still high there, a new handshake starts the next cycle.
- START, ENDD, ER, RT and STOP seen outside their legal states have no effect.

Optional Feature:
- Macro XFER_RESPONDER_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive XFER cycles that have no rdy, rt or endd.
  - When the count reaches TIMEOUT -> ERR, same outputs as an er.
  - The counter clears on any of those strobes and on entry to XFER.
  - stop and er keep priority over the timeout.
- Undefined: no watchdog; XFER may wait indefinitely.

Test Plan:
- rst=0 during XFER with enable=1 -> next cycle: state IDLE, ack/enable/busy/status_valid/interrupt all 0.
- req high 3 cycles then low, start, 5x rdy, endd -> sequence:
  - ack high the cycle after req rises, low the cycle after req falls
  - enable high from the cycle after start
  - status_valid=1, status_err=0, status_beats=5, interrupt=1 one cycle after endd
- In XFER: rdy x2, rt, rdy x3, endd -> status_beats=3, status_err=0.
- In XFER: rt 4 times with MAX_RETRY=3 -> fourth rt gives status_valid=1, status_err=1 the next cycle.
- In XFER: stop and er in the same cycle -> IDLE, no status_valid pulse; er with endd in the same cycle -> status_err=1.
- XFER_RESPONDER_TIMEOUT_EN defined, TIMEOUT=16: start then 16 idle cycles -> status_err=1 pulse. Same stimulus with the macro undefined -> no pulse, enable stays 1.
